// File: rtl/mac_op_sequencer_pkg.sv
// Shared types and widths for the MAC operation sequencer.
// Package name mac_seq_pkg; the done-timeout is enabled with MAC_TIMEOUT_EN.
package mac_seq_pkg;

    localparam int IN_W  = 20;
    localparam int OUT_W = 24;
    localparam int LEN_W = 10;

    typedef enum logic [2:0] {
        OP_SQ      = 3'd0,
        OP_SC      = 3'd1,
        OP_MAT8    = 3'd2,
        OP_MAT16   = 3'd3,
        OP_COL_SUM = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Bit order matches {col_sum, mat16, mat8, sc, sq}; illegal codes map to zero.
    function automatic logic [4:0] op_onehot(input logic [2:0] op);
        case (op)
            OP_SQ:      op_onehot = 5'b00001;
            OP_SC:      op_onehot = 5'b00010;
            OP_MAT8:    op_onehot = 5'b00100;
            OP_MAT16:   op_onehot = 5'b01000;
            OP_COL_SUM: op_onehot = 5'b10000;
            default:    op_onehot = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/mac_op_sequencer_if.sv
// Command, operand, MAC and result signals of the sequencer.
// slave = sequencer side, master = layer controller / MAC / source side.
interface mac_op_sequencer_if;
    import mac_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic             op_valid;
    logic             op_ready;
    logic [IN_W-1:0]  op_in1;
    logic [IN_W-1:0]  op_in2;
    logic             mac_sq;
    logic             mac_sc;
    logic             mac_mat8;
    logic             mac_mat16;
    logic             mac_col_sum;
    logic [IN_W-1:0]  mac_in1;
    logic [IN_W-1:0]  mac_in2;
    logic [OUT_W-1:0] mac_out;
    logic             mac_done;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, op_valid, op_in1, op_in2,
               mac_out, mac_done, res_ready,
        output cmd_ready, op_ready, mac_sq, mac_sc, mac_mat8, mac_mat16,
               mac_col_sum, mac_in1, mac_in2, res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len, op_valid, op_in1, op_in2,
               mac_out, mac_done, res_ready,
        input  cmd_ready, op_ready, mac_sq, mac_sc, mac_mat8, mac_mat16,
               mac_col_sum, mac_in1, mac_in2, res_valid, res_data, res_err
    );

endinterface

// File: rtl/mac_op_sequencer.sv
// Sequences one MAC command: arm mode strobe, stream operand pairs, await done, return result.
// Optional MAC_TIMEOUT_EN: DRAIN gives up after TO_CYC cycles and reports res_err.
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a command
//   ARM    | one cycle with the selected mode strobe high
//   STREAM | op_ready high, pairs forwarded to mac_in*
//   DRAIN  | waiting for mac_done
//   RESP   | result held until res_ready
module mac_op_sequencer
    import mac_seq_pkg::*;
#(
    parameter int TO_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mac_op_sequencer_if.slave  bus
);

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic             cmd_ready_q;
    logic             op_ready_q;
    logic [4:0]       mode_q;
    logic [IN_W-1:0]  in1_q;
    logic [IN_W-1:0]  in2_q;
    logic             res_valid_q;
    logic [OUT_W-1:0] res_data_q;
    logic             res_err_q;
`ifdef MAC_TIMEOUT_EN
    localparam int TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [TO_W-1:0]  to_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mode_q      <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
`ifdef MAC_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        cnt_q       <= bus.cmd_len;
                        if (op_onehot(bus.cmd_op) == 5'b0 || bus.cmd_len == '0) begin
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                            res_data_q  <= '0;
                            state_q     <= ST_RESP;
                        end else begin
                            mode_q  <= op_onehot(bus.cmd_op);
                            state_q <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    mode_q     <= '0;
                    op_ready_q <= 1'b1;
                    state_q    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (bus.op_valid && op_ready_q) begin
                        in1_q <= bus.op_in1;
                        in2_q <= bus.op_in2;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            op_ready_q <= 1'b0;
                            state_q    <= ST_DRAIN;
`ifdef MAC_TIMEOUT_EN
                            to_cnt_q   <= TO_W'(TO_CYC - 1);
`endif
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.mac_done) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= bus.mac_out;
                        res_err_q   <= 1'b0;
                        state_q     <= ST_RESP;
`ifdef MAC_TIMEOUT_EN
                    end else if (to_cnt_q == '0) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q - 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_data_q  <= '0;
                        res_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.op_ready    = op_ready_q;
    assign bus.mac_sq      = mode_q[0];
    assign bus.mac_sc      = mode_q[1];
    assign bus.mac_mat8    = mode_q[2];
    assign bus.mac_mat16   = mode_q[3];
    assign bus.mac_col_sum = mode_q[4];
    assign bus.mac_in1     = in1_q;
    assign bus.mac_in2     = in2_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_mac_op_sequencer.sv
// Directed self-checking bench for mac_op_sequencer (TO_CYC=16 for the timeout case).
module tb_mac_op_sequencer;
    import mac_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mac_op_sequencer_if bus ();

    mac_op_sequencer #(.TO_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.mac_col_sum, bus.mac_mat16, bus.mac_mat8, bus.mac_sc, bus.mac_sq};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_op_ready"},  32'(bus.op_ready),  32'd0);
        chk({tag, "_strobes"},   32'(strobes()),     32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(bus.res_data),  32'd0);
        chk({tag, "_res_err"},   32'(bus.res_err),   32'd0);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [LEN_W-1:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [OUT_W-1:0] val);
        bus.mac_out  = val;
        bus.mac_done = 1'b1;
        step();
        bus.mac_done = 1'b0;
    endtask

    task automatic accept_result();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_in1    = '0;
        bus.op_in2    = '0;
        bus.mac_out   = '0;
        bus.mac_done  = 1'b0;
        bus.res_ready = 1'b0;

        // Reset
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        chk("reset_mac_in1", 32'(bus.mac_in1), 32'd0);

        // 1: MAT8 len 4, no stalls
        send_cmd(3'd2, 10'd4);
        chk("t1_arm_strobe", 32'(strobes()), 32'b00100);
        chk("t1_arm_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("t1_arm_op_ready", 32'(bus.op_ready), 32'd0);
        bus.op_valid = 1'b1;
        bus.op_in1 = 20'd2;
        bus.op_in2 = 20'd2;
        step();
        chk("t1_stream_strobe", 32'(strobes()), 32'd0);
        chk("t1_stream_op_ready", 32'(bus.op_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            bus.op_in1 = 20'(2 + k);
            bus.op_in2 = 20'(2 + k);
            step();
            chk("t1_mac_in1", 32'(bus.mac_in1), 32'(2 + k));
            chk("t1_mac_in2", 32'(bus.mac_in2), 32'(2 + k));
            chk("t1_op_ready", 32'(bus.op_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        bus.op_valid = 1'b0;
        step();
        chk("t1_drain_no_res", 32'(bus.res_valid), 32'd0);
        done_pulse(24'h00ABCD);
        chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t1_res_data", 32'(bus.res_data), 32'h00ABCD);
        chk("t1_res_err", 32'(bus.res_err), 32'd0);
        chk("t1_resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        accept_result();
        check_idle("t1_back_idle");

        // 2: SQ len 3 with two-cycle stalls
        send_cmd(3'd0, 10'd3);
        chk("t2_arm_strobe", 32'(strobes()), 32'b00001);
        step();
        for (int k = 0; k < 3; k++) begin
            bus.op_valid = 1'b1;
            bus.op_in1 = 20'(16 + k);
            bus.op_in2 = 20'(32 + k);
            step();
            bus.op_valid = 1'b0;
            bus.op_in1 = 20'hFFFFF;
            bus.op_in2 = 20'hFFFFF;
            chk("t2_mac_in1", 32'(bus.mac_in1), 32'(16 + k));
            chk("t2_mac_in2", 32'(bus.mac_in2), 32'(32 + k));
            if (k < 2) begin
                step();
                step();
                chk("t2_stall_in1", 32'(bus.mac_in1), 32'(16 + k));
                chk("t2_stall_op_ready", 32'(bus.op_ready), 32'd1);
            end
        end
        chk("t2_op_ready_drop", 32'(bus.op_ready), 32'd0);
        chk("t2_drain_no_res", 32'(bus.res_valid), 32'd0);
        done_pulse(24'h123456);
        chk("t2_res_data", 32'(bus.res_data), 32'h123456);
        accept_result();

        // 3: illegal op, then zero length
        step();
        send_cmd(3'd6, 10'd5);
        chk("t3_strobe", 32'(strobes()), 32'd0);
        chk("t3_op_ready", 32'(bus.op_ready), 32'd0);
        chk("t3_res_valid", 32'(bus.res_valid), 32'd1);
        chk("t3_res_err", 32'(bus.res_err), 32'd1);
        chk("t3_res_data", 32'(bus.res_data), 32'd0);
        accept_result();
        chk("t3_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        send_cmd(3'd1, 10'd0);
        chk("t3_len0_err", 32'(bus.res_err), 32'd1);
        chk("t3_len0_strobe", 32'(strobes()), 32'd0);
        accept_result();

        // 4: COL_SUM len 2, done during last pair ignored, res_ready held off
        bus.mac_out = 24'h777777;
        bus.mac_done = 1'b1;
        step();
        bus.mac_done = 1'b0;
        chk("t4_idle_done_ignored", 32'(bus.res_valid), 32'd0);
        send_cmd(3'd4, 10'd2);
        chk("t4_arm_strobe", 32'(strobes()), 32'b10000);
        step();
        bus.op_valid = 1'b1;
        bus.op_in1 = 20'd100;
        bus.op_in2 = 20'd200;
        step();
        bus.op_in1 = 20'd101;
        bus.op_in2 = 20'd201;
        bus.mac_out = 24'hFFFFFF;
        bus.mac_done = 1'b1;
        step();
        bus.op_valid = 1'b0;
        bus.mac_done = 1'b0;
        chk("t4_last_in1", 32'(bus.mac_in1), 32'd101);
        chk("t4_stream_done_ignored", 32'(bus.res_valid), 32'd0);
        done_pulse(24'h0F0F0F);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd0;
        bus.cmd_len = 10'd1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(bus.res_valid), 32'd1);
            chk("t4_hold_data", 32'(bus.res_data), 32'h0F0F0F);
            chk("t4_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        bus.cmd_valid = 1'b0;
        accept_result();
        check_idle("t4_idle");

        // 5: reset in the middle of streaming
        send_cmd(3'd1, 10'd8);
        step();
        bus.op_valid = 1'b1;
        bus.op_in1 = 20'd55;
        bus.op_in2 = 20'd66;
        step();
        step();
        chk("t5_pre_rst_in1", 32'(bus.mac_in1), 32'd55);
        bus.op_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_after_rst");
        chk("t5_mac_in1", 32'(bus.mac_in1), 32'd0);
        send_cmd(3'd3, 10'd1);
        chk("t5_arm_strobe", 32'(strobes()), 32'b01000);
        step();
        bus.op_valid = 1'b1;
        bus.op_in1 = 20'd7;
        bus.op_in2 = 20'd9;
        step();
        bus.op_valid = 1'b0;
        chk("t5_in2", 32'(bus.mac_in2), 32'd9);
        chk("t5_op_ready", 32'(bus.op_ready), 32'd0);
        done_pulse(24'h000042);
        chk("t5_res_data", 32'(bus.res_data), 32'h000042);
        chk("t5_res_err", 32'(bus.res_err), 32'd0);
        accept_result();

`ifdef MAC_TIMEOUT_EN
        // 6: timeout 16 cycles after DRAIN entry
        send_cmd(3'd1, 10'd1);
        step();
        bus.op_valid = 1'b1;
        step();
        bus.op_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            chk("t6_wait", 32'(bus.res_valid), 32'd0);
        end
        step();
        chk("t6_to_valid", 32'(bus.res_valid), 32'd1);
        chk("t6_to_err", 32'(bus.res_err), 32'd1);
        chk("t6_to_data", 32'(bus.res_data), 32'd0);
        accept_result();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
